// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame controller.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } state_t;

  localparam int unsigned ORDER_GRB = 0;
  localparam int unsigned ORDER_RGB = 1;

  // Latch gap length in clock cycles for a given clock rate and gap in microseconds.
  function automatic int unsigned reset_cycles(input int unsigned clk_hz, input int unsigned gap_us);
    return (clk_hz / 1_000_000) * gap_us;
  endfunction

endpackage

// File: rtl/ws2812_scale.sv
// Combinational per-channel brightness scaling: out = (c * (brightness + 1)) >> 8.
module ws2812_scale (
  input  logic [23:0] i_rgb,
  input  logic [7:0]  i_brightness,
  output logic [23:0] o_rgb
);

  logic [15:0] w_gain;

  assign w_gain = {8'd0, i_brightness} + 16'd1;

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [15:0] w_prod;
    // 255 * 256 is the largest product, so 16 bits never overflow.
    assign w_prod              = {8'd0, i_rgb[ch*8 +: 8]} * w_gain;
    assign o_rgb[ch*8 +: 8]    = w_prod[15:8];
  end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame controller: pixel buffer, prefetch/scale path and frame sequencing
// (load, send, latch gap) feeding an external bit serializer.
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter  int unsigned NUM_LEDS    = 8,
  parameter  int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter  int unsigned RESET_US    = 300,
  parameter  int unsigned COLOR_ORDER = 0,
  localparam int unsigned AW          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic [7:0]    brightness,
  input  logic          auto_refresh,
  input  logic          frame_start,
  input  logic          tx_done,
  output logic          tx_en,
  output logic [23:0]   pixel,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned   RC         = reset_cycles(CLK_FREQ_HZ, RESET_US);
  localparam int unsigned   CW         = (RC > 1) ? $clog2(RC) : 1;
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_LEDS - 1);
  localparam logic [AW-1:0] SECOND_IDX = (NUM_LEDS > 1) ? AW'(1) : '0;
  localparam logic [CW-1:0] LAST_CNT   = CW'(RC - 1);

  state_t        r_state;
  logic          r_load_ph;
  logic [AW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_tx_en;
  logic [23:0]   r_pixel;
  logic          r_frame_done;

  logic [23:0]   r_mem [NUM_LEDS];
  logic [23:0]   r_rd_data;

  logic          w_wr_ok;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic [23:0]   w_scaled;
  logic [23:0]   w_ordered;

  assign w_wr_ok = wr_en && (32'(wr_addr) < NUM_LEDS);

  // Reads happen only at prefetch points, so a later write to an already
  // fetched index waits for the next frame.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    unique case (r_state)
      ST_LOAD: begin
        w_rd_en   = 1'b1;
        w_rd_addr = r_load_ph ? SECOND_IDX : '0;
      end
      ST_SEND: begin
        if (tx_done && (r_idx != LAST_IDX) && (32'(r_idx) + 2 < NUM_LEDS)) begin
          w_rd_en   = 1'b1;
          w_rd_addr = r_idx + AW'(2);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Write-through on a same-index collision so the prefetch sees the new data.
  always_ff @(posedge clk) begin
    if (w_rd_en) begin
      r_rd_data <= (w_wr_ok && (wr_addr == w_rd_addr)) ? wr_data : r_mem[w_rd_addr];
    end
  end

  ws2812_scale u_scale (
    .i_rgb        (r_rd_data),
    .i_brightness (brightness),
    .o_rgb        (w_scaled)
  );

  assign w_ordered = (COLOR_ORDER == ORDER_GRB)
                   ? {w_scaled[15:8], w_scaled[23:16], w_scaled[7:0]}
                   : w_scaled;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_GAP;
      r_load_ph    <= 1'b0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_tx_en      <= 1'b0;
      r_pixel      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (frame_start || auto_refresh) begin
            r_state   <= ST_LOAD;
            r_load_ph <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!r_load_ph) begin
            r_load_ph <= 1'b1;
          end else begin
            r_pixel   <= w_ordered;
            r_idx     <= '0;
            r_tx_en   <= 1'b1;
            r_load_ph <= 1'b0;
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_done) begin
            if (r_idx == LAST_IDX) begin
              r_tx_en      <= 1'b0;
              r_cnt        <= '0;
              r_frame_done <= (RC == 1);
              r_state      <= ST_GAP;
            end else begin
              r_pixel <= w_ordered;
              r_idx   <= r_idx + AW'(1);
            end
          end
        end
        ST_GAP: begin
          if (r_cnt == LAST_CNT) begin
            r_idx     <= '0;
            r_load_ph <= 1'b0;
            r_state   <= auto_refresh ? ST_LOAD : ST_IDLE;
          end else begin
            // Registered pulse lands in the final gap cycle.
            r_cnt        <= r_cnt + CW'(1);
            r_frame_done <= ((r_cnt + CW'(1)) == LAST_CNT);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_en      = r_tx_en;
  assign pixel      = r_pixel;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Self-checking bench for ws2812_frame_ctrl: two instances (GRB and RGB order) share all inputs.
module tb_ws2812_frame_ctrl;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [23:0] wr_data;
  logic [7:0]  brightness;
  logic        auto_refresh;
  logic        frame_start;
  logic        tx_done;

  logic        tx_en_g, busy_g, frame_done_g;
  logic [23:0] pixel_g;
  logic        tx_en_r, busy_r, frame_done_r;
  logic [23:0] pixel_r;

  always #5 clk = ~clk;

  ws2812_frame_ctrl #(
    .NUM_LEDS(3), .CLK_FREQ_HZ(1_000_000), .RESET_US(10), .COLOR_ORDER(0)
  ) u_dut_grb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .brightness(brightness), .auto_refresh(auto_refresh), .frame_start(frame_start),
    .tx_done(tx_done), .tx_en(tx_en_g), .pixel(pixel_g), .busy(busy_g), .frame_done(frame_done_g)
  );

  ws2812_frame_ctrl #(
    .NUM_LEDS(3), .CLK_FREQ_HZ(1_000_000), .RESET_US(10), .COLOR_ORDER(1)
  ) u_dut_rgb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .brightness(brightness), .auto_refresh(auto_refresh), .frame_start(frame_start),
    .tx_done(tx_done), .tx_en(tx_en_r), .pixel(pixel_r), .busy(busy_r), .frame_done(frame_done_r)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] model_buf [N];
  logic [23:0] obs_g [N];
  logic [23:0] obs_r [N];
  int          unstable;
  logic        txen_after_g, txen_after_r;

  bit          hk_en      [N];
  bit          hk_at_done [N];
  logic [1:0]  hk_addr    [N];
  logic [23:0] hk_data    [N];

  // Reference arithmetic: channel * (brightness + 1) / 256, then pick the output byte order.
  function automatic logic [7:0] sc(input logic [7:0] c, input logic [7:0] b);
    int p;
    p = int'(c) * (int'(b) + 1);
    return 8'(p / 256);
  endfunction

  function automatic logic [23:0] expw(input logic [23:0] rgb, input logic [7:0] b, input int order);
    logic [7:0] r, g, bl;
    r  = sc(rgb[23:16], b);
    g  = sc(rgb[15:8], b);
    bl = sc(rgb[7:0], b);
    return (order == 0) ? {g, r, bl} : {r, g, bl};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_px(input logic [1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < 2'(N)) model_buf[a] = d;
  endtask

  task automatic start_frame(output int lat);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    lat = 1;
    while (!tx_en_g && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_g && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Serializer stand-in: captures each word, holds it for a random dwell, then pulses tx_done.
  task automatic serve_frame(input int dmin, input int dmax);
    int d;
    unstable = 0;
    for (int k = 0; k < N; k++) begin
      obs_g[k] = pixel_g;
      obs_r[k] = pixel_r;
      if (tx_en_g !== 1'b1 || tx_en_r !== 1'b1) unstable++;
      d = int'($urandom_range(dmax, dmin));
      for (int j = 0; j < d; j++) begin
        if (hk_en[k] && !hk_at_done[k] && j == 0) begin
          wr_en = 1'b1; wr_addr = hk_addr[k]; wr_data = hk_data[k];
        end
        tick();
        wr_en = 1'b0;
        if (pixel_g !== obs_g[k] || pixel_r !== obs_r[k] || tx_en_g !== 1'b1) unstable++;
      end
      if (hk_en[k] && hk_at_done[k]) begin
        wr_en = 1'b1; wr_addr = hk_addr[k]; wr_data = hk_data[k];
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      wr_en   = 1'b0;
    end
    txen_after_g = tx_en_g;
    txen_after_r = tx_en_r;
    for (int k = 0; k < N; k++) hk_en[k] = 1'b0;
  endtask

  task automatic test_reset();
    int n, fds, fd_at, hi;
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (tx_en_g !== 1'b0) begin n_bad++; $display("FAIL reset_tx_en: got %b want 0", tx_en_g); end
    n_cmp++; if (pixel_g !== 24'h0 || pixel_r !== 24'h0) begin n_bad++; $display("FAIL reset_pixel: got %06h/%06h want 000000", pixel_g, pixel_r); end
    n_cmp++; if (frame_done_g !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done_g); end
    n_cmp++; if (busy_g !== 1'b1 || busy_r !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b/%b want 1", busy_g, busy_r); end
    rst_n = 1'b1;
    n = 0; fds = 0; fd_at = -1;
    while (busy_g && n < 100) begin
      if (n == 2) frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      n++;
      if (frame_done_g) begin fds++; fd_at = n; end
    end
    n_cmp++; if (n != 10) begin n_bad++; $display("FAIL reset_gap_len: got %0d cycles want 10", n); end
    n_cmp++; if (fds != 1 || fd_at != 9) begin n_bad++; $display("FAIL reset_frame_done_pulse: got %0d pulses at cycle %0d want 1 at 9", fds, fd_at); end
    hi = 0;
    for (int i = 0; i < 15; i++) begin
      tx_done = (i == 4);
      tick();
      tx_done = 1'b0;
      if (tx_en_g || busy_g) hi++;
    end
    n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL reset_start_ignored: got %0d active cycles want 0", hi); end
  endtask

  task automatic test_basic_frame();
    int lat, n, fds, fd_at;
    brightness = 8'd255;
    write_px(2'd0, 24'hFF0000);
    write_px(2'd1, 24'h00FF00);
    write_px(2'd2, 24'h0000FF);
    start_frame(lat);
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL basic_start_latency: got %0d want 3", lat); end
    serve_frame(30, 30);
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (obs_g[k] !== expw(model_buf[k], 8'd255, 0)) begin n_bad++; $display("FAIL basic_grb_%0d: got %06h want %06h", k, obs_g[k], expw(model_buf[k], 8'd255, 0)); end
      n_cmp++; if (obs_r[k] !== expw(model_buf[k], 8'd255, 1)) begin n_bad++; $display("FAIL basic_rgb_%0d: got %06h want %06h", k, obs_r[k], expw(model_buf[k], 8'd255, 1)); end
    end
    n_cmp++; if (obs_g[0] !== 24'h00FF00) begin n_bad++; $display("FAIL basic_first_word: got %06h want 00ff00", obs_g[0]); end
    n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL basic_stable: got %0d glitches want 0", unstable); end
    n_cmp++; if (txen_after_g !== 1'b0 || txen_after_r !== 1'b0) begin n_bad++; $display("FAIL basic_tx_en_fall: got %b/%b want 0", txen_after_g, txen_after_r); end
    n = 0; fds = 0; fd_at = -1;
    while (busy_g && n < 100) begin
      tick();
      n++;
      if (frame_done_g) begin fds++; fd_at = n; end
    end
    n_cmp++; if (fds != 1 || fd_at != 9) begin n_bad++; $display("FAIL basic_frame_done: got %0d pulses at cycle %0d want 1 at 9", fds, fd_at); end
    n_cmp++; if (n != 10) begin n_bad++; $display("FAIL basic_gap_len: got %0d want 10", n); end
  endtask

  task automatic test_scale_order();
    int lat, n;
    logic [7:0] bset [6];
    bset[0] = 8'd127; bset[1] = 8'd0; bset[2] = 8'd255;
    for (int i = 3; i < 6; i++) bset[i] = 8'($urandom);
    for (int f = 0; f < 6; f++) begin
      brightness = bset[f];
      for (int k = 0; k < N; k++) write_px(2'(k), (f == 0 && k == 0) ? 24'h804020 : 24'($urandom));
      start_frame(lat);
      serve_frame(1, 6);
      for (int k = 0; k < N; k++) begin
        n_cmp++; if (obs_g[k] !== expw(model_buf[k], bset[f], 0)) begin n_bad++; $display("FAIL scale_grb_f%0d_%0d: got %06h want %06h", f, k, obs_g[k], expw(model_buf[k], bset[f], 0)); end
        n_cmp++; if (obs_r[k] !== expw(model_buf[k], bset[f], 1)) begin n_bad++; $display("FAIL scale_rgb_f%0d_%0d: got %06h want %06h", f, k, obs_r[k], expw(model_buf[k], bset[f], 1)); end
      end
      if (f == 0) begin
        n_cmp++; if (obs_g[0] !== 24'h204010 || obs_r[0] !== 24'h402010) begin n_bad++; $display("FAIL scale_b127: got %06h/%06h want 204010/402010", obs_g[0], obs_r[0]); end
      end
      n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL scale_stable_f%0d: got %0d want 0", f, unstable); end
      wait_idle(n);
      n_cmp++; if (n != 10) begin n_bad++; $display("FAIL scale_gap_f%0d: got %0d want 10", f, n); end
    end
  endtask

  task automatic test_mid_writes();
    int lat, n;
    logic [23:0] a0, a1, a2, n0, n2, m2, e [N];
    brightness = 8'd255;
    a0 = 24'($urandom); a1 = 24'($urandom); a2 = 24'($urandom);
    n0 = 24'($urandom); n2 = 24'($urandom); m2 = 24'($urandom);
    write_px(2'd0, a0); write_px(2'd1, a1); write_px(2'd2, a2);
    hk_en[0] = 1; hk_at_done[0] = 0; hk_addr[0] = 2'd2; hk_data[0] = n2;
    hk_en[1] = 1; hk_at_done[1] = 0; hk_addr[1] = 2'd3; hk_data[1] = 24'($urandom);
    hk_en[2] = 1; hk_at_done[2] = 0; hk_addr[2] = 2'd0; hk_data[2] = n0;
    start_frame(lat);
    serve_frame(2, 5);
    e[0] = a0; e[1] = a1; e[2] = n2;
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (obs_r[k] !== e[k]) begin n_bad++; $display("FAIL midwr_f1_%0d: got %06h want %06h", k, obs_r[k], e[k]); end
    end
    wait_idle(n);
    start_frame(lat);
    serve_frame(1, 4);
    e[0] = n0; e[1] = a1; e[2] = n2;
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (obs_r[k] !== e[k]) begin n_bad++; $display("FAIL midwr_f2_%0d: got %06h want %06h", k, obs_r[k], e[k]); end
    end
    wait_idle(n);
    hk_en[0] = 1; hk_at_done[0] = 1; hk_addr[0] = 2'd2; hk_data[0] = m2;
    start_frame(lat);
    serve_frame(1, 4);
    e[2] = m2;
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (obs_g[k] !== expw(e[k], 8'd255, 0)) begin n_bad++; $display("FAIL midwr_collide_%0d: got %06h want %06h", k, obs_g[k], expw(e[k], 8'd255, 0)); end
    end
    wait_idle(n);
    model_buf[0] = n0; model_buf[1] = a1; model_buf[2] = m2;
  endtask

  task automatic test_back_to_back();
    int lat, j, fd_at, n;
    brightness = 8'($urandom);
    for (int k = 0; k < N; k++) write_px(2'(k), 24'($urandom));
    auto_refresh = 1'b1;
    lat = 0;
    while (!tx_en_g && lat < 200) begin tick(); lat++; end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL b2b_start_latency: got %0d want 3", lat); end
    serve_frame(1, 5);
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (obs_g[k] !== expw(model_buf[k], brightness, 0)) begin n_bad++; $display("FAIL b2b_f1_%0d: got %06h want %06h", k, obs_g[k], expw(model_buf[k], brightness, 0)); end
    end
    // Low time = 10 gap cycles (frame_done in the last) plus the 2-cycle load.
    j = 0; fd_at = -1;
    while (!tx_en_g && j < 100) begin
      tx_done = (j == 2 || j == 6 || j == 10);
      tick();
      tx_done = 1'b0;
      j++;
      if (frame_done_g) fd_at = j;
    end
    auto_refresh = 1'b0;
    n_cmp++; if (fd_at != 9) begin n_bad++; $display("FAIL b2b_frame_done: got cycle %0d want 9", fd_at); end
    n_cmp++; if (j != 12) begin n_bad++; $display("FAIL b2b_low_cycles: got %0d want 12", j); end
    serve_frame(1, 5);
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (obs_r[k] !== expw(model_buf[k], brightness, 1)) begin n_bad++; $display("FAIL b2b_f2_%0d: got %06h want %06h", k, obs_r[k], expw(model_buf[k], brightness, 1)); end
    end
    wait_idle(n);
    n_cmp++; if (n != 10 || busy_g !== 1'b0) begin n_bad++; $display("FAIL b2b_stop: got gap %0d busy %b want 10 and 0", n, busy_g); end
  endtask

  task automatic test_reset_mid_send();
    int lat, n;
    brightness = 8'($urandom);
    start_frame(lat);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    n_cmp++; if (tx_en_g !== 1'b0 || pixel_g !== 24'h0 || pixel_r !== 24'h0) begin n_bad++; $display("FAIL rstsend_outputs: got tx_en %b pixel %06h/%06h want 0", tx_en_g, pixel_g, pixel_r); end
    n_cmp++; if (busy_g !== 1'b1) begin n_bad++; $display("FAIL rstsend_busy: got %b want 1", busy_g); end
    rst_n = 1'b1;
    frame_start = 1'b1;
    n = 0;
    while (!tx_en_g && n < 100) begin tick(); n++; end
    frame_start = 1'b0;
    n_cmp++; if (n != 13) begin n_bad++; $display("FAIL rstsend_restart: got %0d want 13", n); end
    serve_frame(1, 3);
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (obs_g[k] !== expw(model_buf[k], brightness, 0)) begin n_bad++; $display("FAIL rstsend_word_%0d: got %06h want %06h", k, obs_g[k], expw(model_buf[k], brightness, 0)); end
    end
    wait_idle(n);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; brightness = 8'd255;
    auto_refresh = 1'b0; frame_start = 1'b0; tx_done = 1'b0;
    for (int k = 0; k < N; k++) begin
      hk_en[k] = 1'b0; hk_at_done[k] = 1'b0; hk_addr[k] = '0; hk_data[k] = '0; model_buf[k] = '0;
    end
    test_reset();
    test_basic_frame();
    test_scale_order();
    test_mid_writes();
    test_back_to_back();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
